// File: rtl/axis_frame_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_frame_buffer_pkg                                        |
// | Description : Shared definitions for the AXI-Stream frame buffer: default  |
// |               widths, the stored beat layout and parameter-check helpers.  |
// | Contents    : DATA_WIDTH_DEF, KEEP_WIDTH_DEF, DEPTH_DEF, axis_beat_t,      |
// |               is_pow2()                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axis_frame_buffer_pkg;

   localparam int DATA_WIDTH_DEF = 64;
   localparam int KEEP_WIDTH_DEF = DATA_WIDTH_DEF / 8;
   localparam int DEPTH_DEF      = 64;

   // One stored AXI-Stream beat at the default width. Field order is the
   // layout every instance of the buffer RAM uses, whatever its width.
   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] tdata;
      logic [KEEP_WIDTH_DEF-1:0] tkeep;
      logic                      tlast;
   } axis_beat_t;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_frame_buffer_if                                         |
// | Description : AXI-Stream beat channel (tdata/tkeep/tlast/tvalid/tready).  |
// | Modports    : master - drives tdata, tkeep, tlast, tvalid; samples tready  |
// |               slave  - samples tdata, tkeep, tlast, tvalid; drives tready  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface axis_frame_buffer_if #(
   parameter int DATA_WIDTH = axis_frame_buffer_pkg::DATA_WIDTH_DEF
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tlast;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
   modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_frame_buffer_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_frame_buffer_ram                                        |
// | Description : Simple dual-port beat store, synchronous write and           |
// |               asynchronous read, so the head beat appears combinationally  |
// |               from the read pointer.                                       |
// | Ports       : ACLK    - clock                                              |
// |               i_we    - write enable                                       |
// |               i_waddr - write address   i_wdata - beat to store            |
// |               i_raddr - read address    o_rdata - beat at read address     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_frame_buffer_ram
   import axis_frame_buffer_pkg::*;
#(
   parameter type BEAT_T     = axis_beat_t,
   parameter int  DEPTH      = DEPTH_DEF,
   parameter int  ADDR_WIDTH = $clog2(DEPTH)
) (
   input  wire logic            ACLK,
   input  wire logic            i_we,
   input  wire logic [ADDR_WIDTH-1:0] i_waddr,
   input  wire BEAT_T           i_wdata,
   input  wire logic [ADDR_WIDTH-1:0] i_raddr,
   output BEAT_T                o_rdata
);

   // Storage carries no reset: validity is tracked by the pointers/level.
   BEAT_T r_mem [DEPTH];

   always_ff @(posedge ACLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axis_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_frame_buffer                                            |
// | Description : Circular-buffer AXI-Stream FIFO between packet source and    |
// |               Ethernet framer. First-word fall-through, occupancy and      |
// |               complete-frame tracking, sticky oversize flag.               |
// | Config      : `define AXIS_FRAME_BUFFER_STORE_FWD_EN enables store-and-    |
// |               forward gating (output held until a whole frame or a full    |
// |               buffer); default build is cut-through.                       |
// | Ports       : ACLK, ARESET (async, active-high)                            |
// |               S_AXIS   - slave beat channel in  (tready = !full)           |
// |               M_AXIS   - master beat channel out (head of buffer)          |
// |               level    - beats stored                                      |
// |               frames   - stored tlast beats not yet popped (saturating)    |
// |               empty, full - level == 0 / level == DEPTH                    |
// |               oversize - sticky: buffer became full with no tlast stored   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_frame_buffer
   import axis_frame_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int FCNT_WIDTH = 8
) (
   input  wire logic              ACLK,
   input  wire logic              ARESET,
   axis_frame_buffer_if.slave     S_AXIS,
   axis_frame_buffer_if.master    M_AXIS,
   output logic [$clog2(DEPTH):0] level,
   output logic [FCNT_WIDTH-1:0]  frames,
   output logic                   empty,
   output logic                   full,
   output logic                   oversize
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int c_AW       = $clog2(DEPTH);
   localparam int c_LW       = c_AW + 1;
   localparam logic [c_LW-1:0]       c_FULL_LEVEL = c_LW'(DEPTH);
   localparam logic [FCNT_WIDTH-1:0] c_FCNT_MAX   = {FCNT_WIDTH{1'b1}};

   generate
      if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
         $error("axis_frame_buffer: DEPTH must be a power of 2 and >= 4");
      end
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
         $error("axis_frame_buffer: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic [KEEP_WIDTH-1:0] tkeep;
      logic                  tlast;
   } beat_t;

   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_LW-1:0]       r_level;
   logic [FCNT_WIDTH-1:0] r_frames;
   logic                  r_oversize;

   beat_t w_wr_beat;
   beat_t w_rd_beat;
   logic  w_full;
   logic  w_empty;
   logic  w_push;
   logic  w_pop;
   logic  w_out_valid;
   logic  w_push_last;
   logic  w_pop_last;

   assign w_wr_beat.tdata = S_AXIS.tdata;
   assign w_wr_beat.tkeep = S_AXIS.tkeep;
   assign w_wr_beat.tlast = S_AXIS.tlast;

   axis_frame_buffer_ram #(
      .BEAT_T (beat_t),
      .DEPTH  (DEPTH)
   ) u_ram (
      .ACLK    (ACLK),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_beat),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_beat)
   );

   assign w_full  = (r_level == c_FULL_LEVEL);
   assign w_empty = (r_level == '0);

   // No push-through when full: a same-cycle pop does not open tready.
   assign w_push = S_AXIS.tvalid & ~w_full;

`ifdef AXIS_FRAME_BUFFER_STORE_FWD_EN
   // Releasing on full as well as on a complete frame keeps a frame longer
   // than the buffer from deadlocking; it then cuts through.
   assign w_out_valid = ~w_empty & ((r_frames != '0) | w_full);
`else
   assign w_out_valid = ~w_empty;
`endif

   assign w_pop       = w_out_valid & M_AXIS.tready;
   assign w_push_last = w_push & S_AXIS.tlast;
   assign w_pop_last  = w_pop & w_rd_beat.tlast;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_frames   <= '0;
         r_oversize <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         r_level <= r_level + c_LW'(w_push) - c_LW'(w_pop);

         if (w_push_last && !w_pop_last && (r_frames != c_FCNT_MAX)) begin
            r_frames <= r_frames + FCNT_WIDTH'(1);
         end else if (w_pop_last && !w_push_last && (r_frames != '0)) begin
            r_frames <= r_frames - FCNT_WIDTH'(1);
         end

         if (w_full && (r_frames == '0)) begin
            r_oversize <= 1'b1;
         end
      end
   end

   assign S_AXIS.tready = ~w_full;

   // Head beat is forced to zero whenever it is not being offered.
   assign M_AXIS.tvalid = w_out_valid;
   assign M_AXIS.tdata  = w_out_valid ? w_rd_beat.tdata : '0;
   assign M_AXIS.tkeep  = w_out_valid ? w_rd_beat.tkeep : '0;
   assign M_AXIS.tlast  = w_out_valid & w_rd_beat.tlast;

   assign level    = r_level;
   assign frames   = r_frames;
   assign empty    = w_empty;
   assign full     = w_full;
   assign oversize = r_oversize;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_frame_buffer                                         |
// | Description : Self-checking bench for axis_frame_buffer. A queue-based     |
// |               model of the buffer predicts every status and head output;   |
// |               directed scenarios pin the model with literal values, then a |
// |               randomized phase runs under mixed back-pressure.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axis_frame_buffer;

   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 64;
   localparam int FW    = 8;
   localparam int FMAX  = (1 << FW) - 1;
`ifdef AXIS_FRAME_BUFFER_STORE_FWD_EN
   localparam bit SF = 1'b1;
`else
   localparam bit SF = 1'b0;
`endif

   logic ACLK = 1'b0;
   logic ARESET;
   logic [$clog2(DEPTH):0] level;
   logic [FW-1:0]          frames;
   logic                   empty;
   logic                   full;
   logic                   oversize;

   axis_frame_buffer_if #(.DATA_WIDTH(DW)) s_if ();
   axis_frame_buffer_if #(.DATA_WIDTH(DW)) m_if ();

   axis_frame_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .FCNT_WIDTH (FW)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .S_AXIS   (s_if),
      .M_AXIS   (m_if),
      .level    (level),
      .frames   (frames),
      .empty    (empty),
      .full     (full),
      .oversize (oversize)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_s;

   beat_s q[$];
   bit    m_ov;
   bit    chk_en;
   int    n_vec;
   int    n_err;

   function automatic int m_lasts();
      int c = 0;
      foreach (q[i]) if (q[i].l) c++;
      return c;
   endfunction

   function automatic bit m_valid();
      return (q.size() > 0) && (!SF || (m_lasts() > 0) || (q.size() == DEPTH));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances at the same edge as the DUT.
   task automatic drive(input bit tv, input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input bit l, input bit rdy, output bit pushed);
      bit    pu;
      bit    po;
      beat_s b;
      s_if.tvalid  = tv;
      s_if.tdata   = d;
      s_if.tkeep   = k;
      s_if.tlast   = l;
      m_if.tready  = rdy;
      pu = tv && (q.size() < DEPTH);
      po = m_valid() && rdy;
      @(posedge ACLK);
      if ((q.size() == DEPTH) && (m_lasts() == 0)) m_ov = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) begin
         b.d = d; b.k = k; b.l = l;
         q.push_back(b);
      end
      pushed = pu;
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l, input bit rdy);
      bit p = 1'b0;
      for (int i = 0; i < 300 && !p; i++) drive(1'b1, d, k, l, rdy, p);
      chk("send_accept", {63'd0, p}, 64'd1);
   endtask

   task automatic drain();
      bit p;
      for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, p);
      s_if.tvalid = 1'b0;
      chk("drain_empty", {63'd0, empty}, 64'd1);
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge ACLK) begin
      if (chk_en && !ARESET) begin : cmp
         bit ev;
         int lc;
         ev = m_valid();
         lc = m_lasts();
         chk("m_tvalid", {63'd0, m_if.tvalid}, {63'd0, ev});
         chk("s_tready", {63'd0, s_if.tready}, (q.size() < DEPTH) ? 64'd1 : 64'd0);
         chk("level",    {57'd0, level},       64'(q.size()));
         chk("frames",   {56'd0, frames},      64'((lc > FMAX) ? FMAX : lc));
         chk("empty",    {63'd0, empty},       (q.size() == 0) ? 64'd1 : 64'd0);
         chk("full",     {63'd0, full},        (q.size() == DEPTH) ? 64'd1 : 64'd0);
         chk("oversize", {63'd0, oversize},    {63'd0, m_ov});
         if (ev) begin
            chk("m_tdata", m_if.tdata,             q[0].d);
            chk("m_tkeep", {56'd0, m_if.tkeep},    {56'd0, q[0].k});
            chk("m_tlast", {63'd0, m_if.tlast},    {63'd0, q[0].l});
         end else if (q.size() == 0) begin
            chk("idle_tdata", m_if.tdata,          64'd0);
            chk("idle_tkeep", {56'd0, m_if.tkeep}, 64'd0);
            chk("idle_tlast", {63'd0, m_if.tlast}, 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      bit            p;
      bit            have;
      logic [DW-1:0] rd;
      logic [KW-1:0] rk;
      bit            rl;
      n_vec = 0; n_err = 0; m_ov = 1'b0; chk_en = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      ARESET = 1'b0;
      #1 ARESET = 1'b1;
      #1;
      chk("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      chk("rst_s_tready", {63'd0, s_if.tready}, 64'd1);
      chk("rst_empty",    {63'd0, empty},       64'd1);
      chk("rst_full",     {63'd0, full},        64'd0);
      chk("rst_level",    {57'd0, level},       64'd0);
      chk("rst_frames",   {56'd0, frames},      64'd0);
      chk("rst_oversize", {63'd0, oversize},    64'd0);
      chk("rst_tdata",    m_if.tdata,           64'd0);
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESET = 1'b0;
      chk_en = 1'b1;

      // Single beat: fall-through with latency 1.
      drive(1'b1, 64'hA5, 8'hFF, 1'b1, 1'b0, p);
      chk("t1_tvalid", {63'd0, m_if.tvalid}, 64'd1);
      chk("t1_tdata",  m_if.tdata,           64'hA5);
      chk("t1_level",  {57'd0, level},       64'd1);
      chk("t1_frames", {56'd0, frames},      64'd1);
      drain();

      // Three-beat frame: store-and-forward holds until the tlast beat is in.
      send(64'h301, 8'hFF, 1'b0, 1'b1);
      chk("t5_hold1", {63'd0, m_if.tvalid}, SF ? 64'd0 : 64'd1);
      send(64'h302, 8'hFF, 1'b0, 1'b1);
      chk("t5_hold2", {63'd0, m_if.tvalid}, SF ? 64'd0 : 64'd1);
      send(64'h303, 8'h0F, 1'b1, 1'b1);
      chk("t5_release", {63'd0, m_if.tvalid}, 64'd1);
      drain();
      // 70-beat frame: overflows the buffer only under store-and-forward.
      for (int i = 0; i < 70; i++) send(64'h7000 + 64'(i), 8'hFF, i == 69, 1'b1);
      chk("t5_oversize", {63'd0, oversize}, SF ? 64'd1 : 64'd0);
      drain();

      // Fill to full with no tlast; the 65th beat is held off.
      for (int i = 0; i < DEPTH; i++) send(64'h1000 + 64'(i), 8'hFF, 1'b0, 1'b0);
      chk("t2_full",   {63'd0, full},        64'd1);
      chk("t2_tready", {63'd0, s_if.tready}, 64'd0);
      chk("t2_level",  {57'd0, level},       64'd64);
      drive(1'b1, 64'h1040, 8'hFF, 1'b1, 1'b0, p);
      chk("t2_level_hold", {57'd0, level},    64'd64);
      chk("t2_oversize",   {63'd0, oversize}, 64'd1);

      // Full with both readies high: pop only, push lands the next cycle.
      drive(1'b1, 64'h1040, 8'hFF, 1'b1, 1'b1, p);
      chk("t3_level", {57'd0, level}, 64'd63);
      chk("t3_head",  m_if.tdata,     64'h1001);
      drive(1'b1, 64'h1040, 8'hFF, 1'b1, 1'b0, p);
      chk("t3_level_push", {57'd0, level},  64'd64);
      chk("t3_frames",     {56'd0, frames}, 64'd1);
      drain();

      // Continuous streaming through the pointer wrap.
      for (int i = 0; i < 200; i++)
         drive(1'b1, {$urandom, $urandom}, 8'($urandom), 1'b1, 1'b1, p);
      s_if.tvalid = 1'b0;
      chk("t4_level", {57'd0, level}, 64'd1);
      drain();

      // Reset with ten beats buffered discards everything immediately.
      for (int i = 0; i < 10; i++) send(64'h6000 + 64'(i), 8'h0F, i == 4, 1'b0);
      chk("t6_level_pre",  {57'd0, level},  64'd10);
      chk("t6_frames_pre", {56'd0, frames}, 64'd1);
      #2 ARESET = 1'b1;
      #1;
      chk("t6_tvalid",   {63'd0, m_if.tvalid}, 64'd0);
      chk("t6_level",    {57'd0, level},       64'd0);
      chk("t6_frames",   {56'd0, frames},      64'd0);
      chk("t6_tready",   {63'd0, s_if.tready}, 64'd1);
      chk("t6_oversize", {63'd0, oversize},    64'd0);
      q.delete();
      m_ov = 1'b0;
      s_if.tvalid = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;

      // Random traffic; a beat offered upstream is held until accepted.
      have = 1'b0; rd = '0; rk = '0; rl = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!have && ($urandom_range(9) < 7)) begin
            have = 1'b1;
            rd   = {$urandom, $urandom};
            rk   = 8'($urandom);
            rl   = ($urandom_range(5) == 0);
         end
         drive(have, rd, rk, rl, (i < 300) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8), p);
         if (p) have = 1'b0;
      end
      s_if.tvalid = 1'b0;
      @(negedge ACLK);
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
